// File: rtl/register_writeback.sv
// Register-file writeback initiator: load/ALU requests are queued in order and drained one per granted cycle.
// Optional macro REG_WB_BYPASS_EN adds a youngest-match lookup port over the queued entries.
module register_writeback #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 2,
  parameter int DEPTH         = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]            alu_address,
  input  logic [DATA_WIDTH-1:0]               alu_data,
  output logic                                alu_ready,
  input  logic                                load_valid,
  input  logic [ADDRESS_WIDTH-1:0]            load_address,
  input  logic [DATA_WIDTH-1:0]               load_data,
  output logic                                load_ready,
  input  logic                                write_grant,
`ifdef REG_WB_BYPASS_EN
  input  logic [ADDRESS_WIDTH-1:0]            lookup_address,
  output logic                                lookup_hit,
  output logic [DATA_WIDTH-1:0]               lookup_data,
`endif
  output logic                                write_enable,
  output logic [ADDRESS_WIDTH-1:0]            write_address,
  output logic [DATA_WIDTH-1:0]               write_data,
  output logic [(2**ADDRESS_WIDTH)-1:0]       pending,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                full,
  output logic                                empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               push;
  logic               pop;
  entry_t             push_entry;
  entry_t             head_entry;
  logic [DEPTH-1:0]   slot_valid;
  logic [PTR_W-1:0]   slot_offset;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Readies look only at registered occupancy, so a same-cycle pop never frees a slot.
  assign load_ready = !reset && !full;
  assign alu_ready  = !reset && !full && !load_valid;

  assign push       = (load_valid && load_ready) || (alu_valid && alu_ready);
  assign push_entry = load_valid ? '{addr: load_address, data: load_data}
                                 : '{addr: alu_address,  data: alu_data};

  assign head_entry    = mem_q[head_q];
  assign write_enable  = !empty;
  assign write_address = empty ? '0 : head_entry.addr;
  assign write_data    = empty ? '0 : head_entry.data;
  assign pop           = write_enable && write_grant;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    slot_valid  = '0;
    slot_offset = '0;
    pending     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_offset   = PTR_W'(i) - head_q;
      slot_valid[i] = (CNT_W'(slot_offset) < count_q);
      if (slot_valid[i]) begin
        pending[mem_q[i].addr] = 1'b1;
      end
    end
  end

`ifdef REG_WB_BYPASS_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_q) &&
          (mem_q[head_q + PTR_W'(k)].addr == lookup_address)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[head_q + PTR_W'(k)].data;
      end
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is left unreset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback: a queue model predicts drain order, occupancy, pending and readies.
// Define REG_WB_BYPASS_EN to also exercise the lookup port.
module tb_register_writeback;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, load_valid, write_grant;
  logic [AW-1:0] alu_address, load_address;
  logic [DW-1:0] alu_data, load_data;
  logic          alu_ready, load_ready;
  logic          write_enable;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [3:0]    pending;
  logic [2:0]    count;
  logic          full, empty;
`ifdef REG_WB_BYPASS_EN
  logic [AW-1:0] lookup_address;
  logic          lookup_hit;
  logic [DW-1:0] lookup_data;
`endif

  register_writeback #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_address   (alu_address),
    .alu_data      (alu_data),
    .alu_ready     (alu_ready),
    .load_valid    (load_valid),
    .load_address  (load_address),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .write_grant   (write_grant),
`ifdef REG_WB_BYPASS_EN
    .lookup_address(lookup_address),
    .lookup_hit    (lookup_hit),
    .lookup_data   (lookup_data),
`endif
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .pending       (pending),
    .count         (count),
    .full          (full),
    .empty         (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model mid-cycle, then advance one edge and update the model.
  task automatic tick();
    logic [3:0] exp_pend;
    logic       exp_lr, exp_ar;
    exp_t       e;
    @(negedge clock);
    exp_pend = '0;
    foreach (sb[i]) exp_pend[sb[i].a] = 1'b1;
    exp_lr = !reset && (sb.size() < DEPTH);
    exp_ar = exp_lr && !load_valid;
    chk("count",        32'(count),        32'(sb.size()));
    chk("full",         32'(full),         32'(sb.size() == DEPTH));
    chk("empty",        32'(empty),        32'(sb.size() == 0));
    chk("pending",      32'(pending),      32'(exp_pend));
    chk("write_enable", 32'(write_enable), 32'(sb.size() != 0));
    chk("write_address",32'(write_address),(sb.size() != 0) ? 32'(sb[0].a) : 32'd0);
    chk("write_data",   32'(write_data),   (sb.size() != 0) ? 32'(sb[0].d) : 32'd0);
    chk("load_ready",   32'(load_ready),   32'(exp_lr));
    chk("alu_ready",    32'(alu_ready),    32'(exp_ar));
    @(posedge clock);
    if (reset) begin
      sb.delete();
    end else begin
      if (write_grant && sb.size() != 0) void'(sb.pop_front());
      if (load_valid && exp_lr) begin
        e.a = load_address; e.d = load_data; sb.push_back(e);
      end else if (alu_valid && exp_ar) begin
        e.a = alu_address; e.d = alu_data; sb.push_back(e);
      end
    end
    #1;
  endtask

  task automatic alu_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    alu_valid = 1'b1; alu_address = a; alu_data = d;
    tick();
    alu_valid = 1'b0;
  endtask

`ifdef REG_WB_BYPASS_EN
  task automatic check_lookup(input logic [AW-1:0] a);
    logic          hit;
    logic [DW-1:0] d;
    lookup_address = a;
    #1;
    hit = 1'b0; d = '0;
    foreach (sb[i]) if (sb[i].a == a) begin hit = 1'b1; d = sb[i].d; end
    chk("lookup_hit",  32'(lookup_hit),  32'(hit));
    chk("lookup_data", 32'(lookup_data), 32'(d));
  endtask
`endif

  initial begin
    reset = 1'b1; write_grant = 1'b1;
    alu_valid = 1'b0; alu_address = '0; alu_data = '0;
    load_valid = 1'b0; load_address = '0; load_data = '0;
`ifdef REG_WB_BYPASS_EN
    lookup_address = '0;
`endif
    @(posedge clock); #1;
    tick();
    reset = 1'b0;
    tick(); tick();

    // Single ALU write: visible the cycle after acceptance, gone after the grant.
    alu_req(2'd2, 8'hA5);
    tick(); tick();

    // Fill with grant low; the fifth request is refused, then drain in order.
    write_grant = 1'b0;
    for (int i = 0; i < 5; i++) alu_req(AW'(i % 4), DW'(i + 1));
    write_grant = 1'b1;
    repeat (5) tick();

    // Load wins over ALU; the held ALU request goes in the following cycle.
    load_valid = 1'b1; load_address = 2'd1; load_data = 8'h10;
    alu_valid  = 1'b1; alu_address  = 2'd3; alu_data  = 8'h20;
    tick();
    load_valid = 1'b0;
    tick();
    alu_valid = 1'b0;
    tick(); tick();

    // Full queue refuses a load even while popping; space reappears next cycle.
    write_grant = 1'b0;
    for (int i = 0; i < 4; i++) alu_req(AW'(3 - i), DW'(8'h40 + i));
    write_grant = 1'b1;
    load_valid = 1'b1; load_address = 2'd2; load_data = 8'h77;
    tick();
    write_grant = 1'b0;
    tick();
    load_valid = 1'b0;
    tick();
    write_grant = 1'b1;
    repeat (5) tick();

`ifdef REG_WB_BYPASS_EN
    // Two entries to the same register: lookup returns the younger one.
    write_grant = 1'b0;
    alu_req(2'd1, 8'h11);
    alu_req(2'd1, 8'h22);
    check_lookup(2'd1);
    check_lookup(2'd0);
    write_grant = 1'b1;
    tick();
    check_lookup(2'd1);
    tick(); tick();
`endif

    // Mid-operation reset discards queued entries and masks readies.
    write_grant = 1'b0;
    for (int i = 0; i < 3; i++) alu_req(AW'(i), DW'(8'h60 + i));
    reset = 1'b1; alu_valid = 1'b1; load_valid = 1'b1;
    tick();
    reset = 1'b0; alu_valid = 1'b0; load_valid = 1'b0; write_grant = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_writeback.md
Name: register_writeback

Overview:
- Initiator side of the general-purpose register file write port. Drives write_address, write_data and write_enable into the register file.
- Accepts writeback requests from two producers, the ALU and the load path, through valid/ready handshakes.
- Buffers requests in an in-order FIFO and drains one entry per granted cycle.
- Exports a per-register pending mask so issue logic can detect outstanding writes.

Parameters:
- DATA_WIDTH, 8, width of register data.
- ADDRESS_WIDTH, 2, register index width; register count = 2**ADDRESS_WIDTH.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU writeback request.
- alu_address  input  ADDRESS_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- load_valid  input  1  load writeback request.
- load_address  input  ADDRESS_WIDTH  load destination register.
- load_data  input  DATA_WIDTH  load result.
- load_ready  output  1  load request accepted this cycle.
- write_grant  input  1  register file write port available this cycle.
- write_enable  output  1  to register file.
- write_address  output  ADDRESS_WIDTH  to register file.
- write_data  output  DATA_WIDTH  to register file.
- pending  output  2**ADDRESS_WIDTH  bit r set while any queued entry targets register r.
- count  output  clog2(DEPTH)+1  number of queued entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset, sampled on the rising clock edge:
  - Clears the head pointer, tail pointer and count.
  - Discards all queued entries, including in-flight ones when reset is asserted mid-operation.
- Outputs after reset:
  - count=0, empty=1, full=0, pending=0.
  - write_enable=0, write_address=0, write_data=0.
- alu_ready and load_ready are forced to 0 in any cycle where reset is high.
- Arbitration is fixed priority, load over ALU, with at most one enqueue per cycle:
  - load_ready = !full.
  - alu_ready = !full && !load_valid.
- A transfer occurs on a clock edge where valid && ready is true. The entry is written at the tail and the tail wraps modulo DEPTH.
- No enqueue is accepted when full, even if a pop happens in the same cycle. The ready signals depend only on registered state.
- Drain side (combinational from the head entry):
  - write_enable = !empty.
  - write_address and write_data = head entry when not empty, otherwise 0.
- Pop happens on an edge where write_enable && write_grant. The head then advances modulo DEPTH.
- A write_grant low stalls the head; the outputs hold stable.
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Ordering is strictly FIFO: an entry accepted at edge N is presented on the write port from cycle N+1 at the earliest. The minimum latency from acceptance to register file write is 1 cycle.
- Multiple queued entries to the same register are all written, in order; they are not merged.
- pending is combinational over all valid entries. Its bit clears in the cycle after the last matching entry pops, unless a new matching entry is enqueued on the same edge.
- count, full and empty always reflect registered state after the most recent edge.

Optional Feature:
- Macro REG_WB_BYPASS_EN.
- When defined, the block adds these ports:
  - lookup_address  input  ADDRESS_WIDTH.
  - lookup_hit  output  1.
  - lookup_data  output  DATA_WIDTH.
- Lookup behaviour:
  - Combinational search of the queue for the youngest valid entry whose address matches lookup_address.
  - On a match, lookup_hit=1 and lookup_data is that entry's data.
  - With no match, lookup_hit=0 and lookup_data=0.
  - The head entry counts as valid in the cycle it pops.
- When the macro is not defined, these ports and the search logic do not exist. All other behaviour is identical.

Test Plan:
- Reset then idle, write_grant=1 -> write_enable=0, count=0, empty=1, pending=0000. Assert reset with 3 entries queued -> next cycle count=0, write_enable=0, pending=0000.
- Single ALU request addr=2, data=8'hA5, write_grant=1 -> next cycle write_enable=1, write_address=2, write_data=A5, pending=0100. One cycle later write_enable=0 and pending=0000.
- write_grant=0 with 5 ALU requests addr 0,1,2,3,0 and data 1..5 -> first 4 accepted, full=1, fifth sees alu_ready=0. Then write_grant=1 -> writes (0,1),(1,2),(2,3),(3,4) appear on consecutive cycles.
- Both alu_valid and load_valid high, load addr=1 data=8'h10, ALU addr=3 data=8'h20 -> load_ready=1, alu_ready=0. The load write appears first; the held ALU request is accepted the next cycle and written after it.
- Full queue with write_grant=1 and load_valid=1 -> load_ready=0. After the pop, count=3 and full=0; the next cycle accepts and count returns to 4.
- REG_WB_BYPASS_EN defined, write_grant=0, queue (1,8'h11),(1,8'h22), lookup_address=1 -> lookup_hit=1, lookup_data=22. With lookup_address=0 -> lookup_hit=0, lookup_data=0.
